booth_radix4_multiplier: RTL and testbench

Sequential radix-4 Booth multiplier producing a full-width 2*WORD_LENGTH product with a start/ready/done handshake.
Per-operation signed or unsigned mode.
Retires one radix-4 digit (two multiplier bits) per clock.
Successor to the fixed 8-bit multiplier in the arithmetic datapath; sits between operand registers and the accumulator stage.

---
 rtl/booth_pkg.sv | 11 +
 rtl/booth_r4_encoder.sv | 12 +
 rtl/booth_radix4_multiplier.sv | 98 +++++++++
 tb/tb_booth_radix4_multiplier.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state/select encodings and sizing helpers for the radix-4 Booth multiplier
package booth_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_sel_e;
    function automatic int booth_iter(input int w);
        return w / 2 + 1;
    endfunction
    function automatic int booth_acc_w(input int w);
        return 2 * w + 4;
    endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} to a Booth digit select
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0]  win,
    output booth_sel_e  sel
);
    assign sel = (win == 3'b000 || win == 3'b111) ? ZERO :
                 (win == 3'b011) ? POS2 :
                 (win == 3'b100) ? NEG2 :
                 win[2] ? NEG1 : POS1;
endmodule

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: sequential radix-4 Booth multiplier, one digit per clock, signed/unsigned per op.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand skips CALC and completes in one cycle with Result=0.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int WORD_LENGTH = 8
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       Sign,
    input  logic [WORD_LENGTH-1:0]     Multiplicand,
    input  logic [WORD_LENGTH-1:0]     Multiplier,
    output logic                       ready,
    output logic                       done,
    output logic [2*WORD_LENGTH-1:0]   Result
);
    localparam int ITER = booth_iter(WORD_LENGTH);
    localparam int AW   = booth_acc_w(WORD_LENGTH);
    localparam int EW   = WORD_LENGTH + 2;
    localparam int CW   = $clog2(ITER + 1);

    if ((WORD_LENGTH % 2) != 0 || WORD_LENGTH < 4) begin : g_bad_width
        $error("WORD_LENGTH must be even and >= 4");
    end

    state_e            state, next;
    logic [CW-1:0]     cnt;
    logic [EW-1:0]     a_reg;
    logic [EW:0]       b_reg;
    logic [AW-1:0]     acc, acc_nxt;
    logic signed [AW-1:0] sum;
    logic [EW-1:0]     mag, term;
    logic              neg, zero, last;
    booth_sel_e        sel;

    function automatic logic [EW-1:0] ext(input logic [WORD_LENGTH-1:0] x, input logic s);
        return {{2{s & x[WORD_LENGTH-1]}}, x};
    endfunction

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero = (Multiplicand == '0) || (Multiplier == '0);
`else
    assign zero = 1'b0;
`endif

    booth_r4_encoder u_enc (.win(b_reg[2:0]), .sel(sel));

    // The addend sits at bit EW so that ITER shifts of two bits land the product at bit 0
    assign neg     = (sel == NEG1) || (sel == NEG2);
    assign mag     = (sel == POS2 || sel == NEG2) ? {a_reg[EW-2:0], 1'b0} : a_reg;
    assign term    = (sel == ZERO) ? '0 : neg ? ~mag : mag;
    assign sum     = acc + {term, {EW{1'b0}}} + (AW'(neg) << EW);
    assign acc_nxt = sum >>> 2;
    assign last    = cnt == CW'(ITER - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;

    always_comb begin
        next  = state;
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next = zero ? DONE : CALC;
            end
            CALC: if (last) next = DONE;
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            Result <= '0;
        end else if (state == IDLE && start) begin
            cnt   <= '0;
            a_reg <= ext(Multiplicand, Sign);
            b_reg <= {ext(Multiplier, Sign), 1'b0};
            acc   <= '0;
            if (zero) Result <= '0;
        end else if (state == CALC) begin
            cnt   <= cnt + 1'b1;
            acc   <= acc_nxt;
            b_reg <= b_reg >> 2;
            if (last) Result <= acc_nxt[2*WORD_LENGTH-1:0];
        end
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier: directed and random checks of the Booth multiplier against an arithmetic model
`timescale 1ns/1ps
module tb_booth_radix4_multiplier;
    localparam int W    = 8;
    localparam int ITER = W / 2 + 1;
`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, start, Sign;
    logic [W-1:0]   Multiplicand, Multiplier;
    logic           ready, done;
    logic [2*W-1:0] Result;
    int             ncmp = 0, nerr = 0;
    int             lat;
    bit             bad;
    logic [W-1:0]   ra, rb;
    logic           rs;

    booth_radix4_multiplier #(.WORD_LENGTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .Sign(Sign),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .ready(ready), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, b, input logic s);
        int p;
        p = s ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
        return p[2*W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, b, input logic s);
        @(negedge clk);
        start = 1'b1; Multiplicand = a; Multiplier = b; Sign = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        Multiplicand = W'($urandom); Multiplier = W'($urandom); Sign = 1'($urandom);
    endtask

    task automatic wait_done(output int l, output bit rdy_bad);
        l = 0;
        rdy_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            l++;
            if (ready) rdy_bad = 1'b1;
            if (done) break;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, b, input logic s, input string tag);
        int l;
        bit rb_bad;
        logic [2*W-1:0] exp;
        int elat;
        exp  = ref_mul(a, b, s);
        elat = (ZS && (a == 0 || b == 0)) ? 1 : ITER + 1;
        issue(a, b, s);
        wait_done(l, rb_bad);
        check({tag, "_lat"}, l, elat);
        check({tag, "_res"}, Result, exp);
        check({tag, "_rdy_low"}, rb_bad, 0);
        @(negedge clk);
        check({tag, "_pulse"}, {ready, done}, 2'b10);
        check({tag, "_held"}, Result, exp);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; Sign = 1'b0; Multiplicand = '0; Multiplier = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", Result, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", ready, 1);

        run_op(8'd7, 8'd13, 1'b0, "t1");
        check("t1_value", Result, 16'h005B);
        run_op(8'hF9, 8'd13, 1'b1, "t2");
        check("t2_value", Result, 16'hFFA5);
        run_op(8'hFF, 8'hFF, 1'b0, "t3a");
        check("t3a_value", Result, 16'hFE01);
        run_op(8'h80, 8'h80, 1'b1, "t3b");
        check("t3b_value", Result, 16'h4000);
        run_op(8'h80, 8'h7F, 1'b1, "t3c");
        check("t3c_value", Result, 16'hC080);
        run_op(8'hFF, 8'hFF, 1'b1, "t3d");
        run_op(8'h00, 8'h5A, 1'b1, "t3z");
        run_op(8'hC3, 8'h00, 1'b0, "t3y");

        issue(8'd3, 8'd5, 1'b0);
        for (int c = 1; c <= ITER + 1; c++) begin
            @(negedge clk);
            if (c == 2) begin start = 1'b1; Multiplicand = 8'd100; Multiplier = 8'd100; end
            if (c == 3) start = 1'b0;
        end
        check("t4_done", done, 1);
        check("t4_res", Result, 16'd15);
        start = 1'b1; Multiplicand = 8'd9; Multiplier = 8'd10; Sign = 1'b0;
        @(negedge clk);
        check("t4_idle", {ready, done}, 2'b10);
        check("t4_hold", Result, 16'd15);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bad);
        check("t4_lat2", lat, ITER + 1);
        check("t4_res2", Result, 16'd90);

        issue(8'd3, 8'd7, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_ready", ready, 1);
        check("t5_done", done, 0);
        check("t5_result", Result, 0);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
        end
        reset = 1'b1;
        repeat (ITER + 2) begin
            @(negedge clk);
            check("t5_quiet", {ready, done}, 2'b10);
        end
        run_op(8'd100, 8'd200, 1'b0, "t5b");

        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 15) == 0) ra = '0;
            if ($urandom_range(0, 15) == 0) rb = '0;
            run_op(ra, rb, rs, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
